// File: rtl/fb_addr_to_xy.sv
// Converts a linear framebuffer address back into (x, y) pixel coordinates
// using a restoring shift-subtract divider that resolves one quotient bit per cycle.
module fb_addr_to_xy #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_BITS = 20,
    localparam int FB_X_BITS = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1,
    localparam int FB_Y_BITS = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FB_X_BITS-1:0] x,
    output logic [FB_Y_BITS-1:0] y,
    output logic                 err
);

    // The divisor is shifted by up to FB_Y_BITS-1, so the compare is done
    // wide enough that the shifted divisor never loses its top bits.
    localparam int WIDE     = ADDR_BITS + FB_Y_BITS;
    localparam int CNT_BITS = (FB_Y_BITS > 1) ? $clog2(FB_Y_BITS) : 1;
    localparam logic [WIDE-1:0] DIVISOR = WIDE'(FB_WIDTH);
    localparam logic [WIDE-1:0] AREA    = WIDE'(FB_WIDTH * FB_HEIGHT);
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(FB_Y_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   rem_reg, rem_next;
    logic [FB_Y_BITS-1:0]   q_reg, q_next;
    logic [CNT_BITS-1:0]    cnt_reg, cnt_next;
    logic                   err_reg, err_next;
    logic [FB_X_BITS-1:0]   x_reg, x_next;
    logic [FB_Y_BITS-1:0]   y_reg, y_next;

    logic [WIDE-1:0]        rem_wide;
    logic [WIDE-1:0]        div_shifted;

    assign rem_wide    = WIDE'(rem_reg);
    assign div_shifted = DIVISOR << cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        x_next     = x_reg;
        y_next     = y_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    rem_next   = addr;
                    q_next     = '0;
                    cnt_next   = LAST_BIT;
                    err_next   = (WIDE'(addr) >= AREA);
                    state_next = DIV;
                end
            end
            DIV: begin
                if (rem_wide >= div_shifted) begin
                    rem_next        = ADDR_BITS'(rem_wide - div_shifted);
                    q_next[cnt_reg] = 1'b1;
                end
                if (cnt_reg == '0) begin
                    // Out-of-range addresses still run the full division so
                    // latency is identical; only the published result is zeroed.
                    x_next     = err_reg ? '0 : rem_next[FB_X_BITS-1:0];
                    y_next     = err_reg ? '0 : q_next;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_BITS'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign x         = x_reg;
    assign y         = y_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_fb_addr_to_xy.sv
// Bench for fb_addr_to_xy: directed, random and backpressure cases on a 640x480
// instance, plus a full address sweep of a 100x75 instance against an arithmetic model.
module tb_fb_addr_to_xy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [19:0] addr;
    logic [9:0]  x;
    logic [8:0]  y;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err;
    logic [19:0] s_addr;
    logic [6:0]  s_x;
    logic [6:0]  s_y;

    int errors = 0;
    int checks = 0;

    fb_addr_to_xy dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .err       (err)
    );

    fb_addr_to_xy #(
        .FB_WIDTH  (100),
        .FB_HEIGHT (75),
        .ADDR_BITS (20)
    ) dut_s (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .addr      (s_addr),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .x         (s_x),
        .y         (s_y),
        .err       (s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain division/modulo with the out-of-frame rule applied.
    function automatic void model(input int w, input int h, input int a,
                                  output int ex, output int ey, output int ee);
        ee = (a >= w * h) ? 1 : 0;
        ex = ee ? 0 : a % w;
        ey = ee ? 0 : a / w;
    endfunction

    // Called #1 after an accepting edge; counts edges until out_valid shows.
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_txn(input logic [19:0] a);
        int ex, ey, ee, lat;
        model(640, 480, int'(a), ex, ey, ee);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        addr      = a;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        addr     = 20'($urandom);
        wait_valid(0, lat);
        check("latency", 32'(lat), 32'd9);
        check("x", 32'(x), 32'(ex));
        check("y", 32'(y), 32'(ey));
        check("err", 32'(err), 32'(ee));
        $display("txn addr=%0d x=%0d y=%0d err=%0d lat=%0d", a, x, y, err, lat);
        @(posedge clk); #1;
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int ex, ey, ee, lat, seen;
        logic [9:0] hold_x;
        logic [8:0] hold_y;
        logic [19:0] ra;

        reset = 1'b1;
        in_valid = 1'b0; addr = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_addr = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed and boundary addresses
        run_txn(20'd0);
        run_txn(20'd1);
        run_txn(20'd640);
        run_txn(20'd641);
        run_txn(20'd307199);
        run_txn(20'd307200);
        run_txn(20'd1048575);

        // Random addresses, half biased into the visible frame
        for (int i = 0; i < 40; i++) begin
            ra = (i % 2 == 0) ? 20'($urandom_range(0, 307199)) : 20'($urandom);
            run_txn(ra);
        end

        // Backpressure: result must hold steady while out_ready is low
        model(640, 480, 12345, ex, ey, ee);
        addr = 20'd12345; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(0, lat);
        check("bp_latency", 32'(lat), 32'd9);
        check("bp_x", 32'(x), 32'(ex));
        check("bp_y", 32'(y), 32'(ey));
        hold_x = x; hold_y = y;
        $display("txn addr=12345 x=%0d y=%0d err=%0d lat=%0d (held)", x, y, err, lat);
        repeat (20) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_x_stable", 32'(x), 32'(hold_x));
            check("bp_y_stable", 32'(y), 32'(hold_y));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Busy rejection: in_valid/addr wiggle during DIV must be ignored
        model(640, 480, 1000, ex, ey, ee);
        addr = 20'd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin
            in_valid = 1'($urandom);
            addr     = 20'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_valid(6, lat);
        check("busy_latency", 32'(lat), 32'd9);
        check("busy_x", 32'(x), 32'(ex));
        check("busy_y", 32'(y), 32'(ey));
        $display("txn addr=1000 x=%0d y=%0d err=%0d lat=%0d (busy wiggle)", x, y, err, lat);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("busy_single_result", 32'(seen), 32'd0);

        // Reset in the middle of a division
        addr = 20'd641; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_x", 32'(x), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_spurious", 32'(seen), 32'd0);
        $display("txn reset mid-division, no result");
        run_txn(20'd641);

        // Full sweep of the 100x75 instance, including the first invalid address
        for (int a = 0; a <= 7500; a++) begin
            model(100, 75, a, ex, ey, ee);
            s_addr = 20'(a); s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            lat = 0;
            while (!s_out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("s_latency", 32'(lat), 32'd7);
            check("s_x", 32'(s_x), 32'(ex));
            check("s_y", 32'(s_y), 32'(ey));
            check("s_err", 32'(s_err), 32'(ee));
            $display("txn w100 addr=%0d x=%0d y=%0d err=%0d", a, s_x, s_y, s_err);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
